// File: rtl/secded_pkg.sv
// Shared types and Hamming SECDED helpers for the SECDED memory engine.
// Helpers work on MaxCw-wide vectors; the active codeword width is passed at call time.
package secded_pkg;

  localparam int unsigned MaxCw = 32;

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDone} state_e;
  typedef enum logic {ModeEnc = 1'b0, ModeDec = 1'b1} mode_e;

  function automatic logic is_parity_pos(int unsigned pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  // Data bits fill the non-power-of-two positions; each parity bit covers its index bit.
  function automatic logic [MaxCw-1:0] secded_encode(logic [MaxCw-1:0] data, int unsigned cw);
    logic [MaxCw-1:0] word;
    int unsigned      d;
    word = '0;
    d    = 0;
    for (int unsigned i = 1; i < MaxCw; i++) begin
      if (i < cw && !is_parity_pos(i)) begin
        word[i] = data[d];
        d++;
      end
    end
    for (int unsigned k = 0; k < 5; k++) begin
      for (int unsigned i = 1; i < MaxCw; i++) begin
        if (i < cw && !is_parity_pos(i) && i[k]) begin
          word[1 << k] = word[1 << k] ^ word[i];
        end
      end
    end
    word[0] = ^word[MaxCw-1:1];
    return word;
  endfunction

  function automatic logic [4:0] secded_syndrome(logic [MaxCw-1:0] word, int unsigned cw);
    logic [4:0] syn;
    syn = '0;
    for (int unsigned i = 1; i < MaxCw; i++) begin
      if (i < cw && word[i]) begin
        syn = syn ^ i[4:0];
      end
    end
    return syn;
  endfunction

  function automatic logic [MaxCw-1:0] secded_extract(logic [MaxCw-1:0] word, int unsigned cw);
    logic [MaxCw-1:0] data;
    int unsigned      d;
    data = '0;
    d    = 0;
    for (int unsigned i = 1; i < MaxCw; i++) begin
      if (i < cw && !is_parity_pos(i)) begin
        data[d] = word[i];
        d++;
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED codec: encode a data word, or decode/correct a codeword into
// {DED, SEC, zero fill, data}.
module secded_codec
  import secded_pkg::*;
#(
  parameter int unsigned DW = 11,
  parameter int unsigned CW = DW + $clog2(DW + 1) + 1
) (
  input  logic          mode,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] dout,
  output logic          sec,
  output logic          ded
);

  logic [MaxCw-1:0] word;
  logic [MaxCw-1:0] data_in;
  logic [MaxCw-1:0] fixed;
  logic [MaxCw-1:0] ext;
  logic [MaxCw-1:0] res;
  logic [4:0]       syn;
  logic             par;

  always_comb begin
    word          = '0;
    word[CW-1:0]  = din;
    data_in       = '0;
    data_in[DW-1:0] = din[DW-1:0];
    syn           = secded_syndrome(word, CW);
    par           = ^word;
    fixed         = word;
    sec           = 1'b0;
    ded           = 1'b0;
    ext           = '0;
    res           = '0;
    if (mode_e'(mode) == ModeEnc) begin
      res = secded_encode(data_in, CW);
    end else begin
      if (par) begin
        // Odd overall parity: single error; syndrome 0 means only bit 0 flipped.
        sec = 1'b1;
        if (syn != '0) begin
          fixed[syn] = ~fixed[syn];
        end
      end else if (syn != '0) begin
        ded = 1'b1;
      end
      ext             = secded_extract(fixed, CW);
      res[DW-1:0]     = ext[DW-1:0];
      res[CW-1]       = ded;
      res[CW-2]       = sec;
    end
    dout = res[CW-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{res, ext};

endmodule

// File: rtl/hamming_secded_engine.sv
// Memory-to-memory SECDED engine: reads NWORDS words, encodes or decodes/corrects each,
// and writes them to a destination block, counting corrected and uncorrectable words.
module hamming_secded_engine
  import secded_pkg::*;
#(
  parameter int unsigned DW     = 11,
  parameter int unsigned CW     = DW + $clog2(DW + 1) + 1,
  parameter int unsigned NWORDS = 15,
  parameter int unsigned AW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          mode,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          ack,
  output logic          busy,
  output logic          mem_rd_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic [CW-1:0] mem_rdata,
  output logic [CW-1:0] mem_wdata,
  output logic [7:0]    sec_cnt,
  output logic [7:0]    ded_cnt
);

  localparam logic [7:0] LastIdx = 8'(NWORDS - 1);

  state_e        state_q;
  mode_e         mode_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [7:0]    idx_q;
  logic [CW-1:0] result;
  logic          sec;
  logic          ded;

  secded_codec #(
    .DW(DW),
    .CW(CW)
  ) u_codec (
    .mode(mode_q),
    .din (mem_rdata),
    .dout(result),
    .sec (sec),
    .ded (ded)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mode_q    <= ModeEnc;
      src_q     <= '0;
      dst_q     <= '0;
      idx_q     <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sec_cnt   <= '0;
      ded_cnt   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (req) begin
            state_q   <= StRd;
            mode_q    <= mode_e'(mode);
            src_q     <= src_base;
            dst_q     <= dst_base;
            idx_q     <= '0;
            ack       <= 1'b0;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= src_base;
            if (mode_e'(mode) == ModeDec) begin
              sec_cnt <= '0;
              ded_cnt <= '0;
            end
          end
        end
        StRd: begin
          mem_rd_en <= 1'b0;
          state_q   <= StCap;
        end
        StCap: begin
          // Read data is valid this cycle; the codec output is captured as the write data.
          mem_wdata <= result;
          if (sec && sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
          if (ded && ded_cnt != 8'hFF) ded_cnt <= ded_cnt + 8'd1;
          mem_we    <= 1'b1;
          mem_addr  <= dst_q + AW'(idx_q);
          state_q   <= StWr;
        end
        StWr: begin
          mem_we <= 1'b0;
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            ack     <= 1'b1;
            busy    <= 1'b0;
          end else begin
            idx_q     <= idx_q + 8'd1;
            mem_rd_en <= 1'b1;
            mem_addr  <= src_q + AW'(idx_q + 8'd1);
            state_q   <= StRd;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_secded_engine.sv
// Scoreboard bench for hamming_secded_engine at DW=11 (directed) plus DW=4 and DW=26 sweeps.
module tb_hamming_secded_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       mode;
  logic [7:0] src_base, dst_base;
  logic       req11, req4, req26;

  logic        ack11, busy11, rd11, we11;
  logic [7:0]  addr11, sec11, ded11;
  logic [15:0] rdata11, wdata11;
  logic        ack4, busy4, rd4, we4;
  logic [7:0]  addr4, sec4, ded4;
  logic [7:0]  rdata4, wdata4;
  logic        ack26, busy26, rd26, we26;
  logic [7:0]  addr26, sec26, ded26;
  logic [31:0] rdata26, wdata26;

  hamming_secded_engine #(.DW(11), .NWORDS(15), .AW(8)) u_dut (
    .clk(clk), .reset(reset), .req(req11), .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .ack(ack11), .busy(busy11), .mem_rd_en(rd11), .mem_we(we11),
    .mem_addr(addr11), .mem_rdata(rdata11), .mem_wdata(wdata11), .sec_cnt(sec11),
    .ded_cnt(ded11)
  );
  hamming_secded_engine #(.DW(4), .NWORDS(8), .AW(8)) u_d4 (
    .clk(clk), .reset(reset), .req(req4), .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .ack(ack4), .busy(busy4), .mem_rd_en(rd4), .mem_we(we4),
    .mem_addr(addr4), .mem_rdata(rdata4), .mem_wdata(wdata4), .sec_cnt(sec4),
    .ded_cnt(ded4)
  );
  hamming_secded_engine #(.DW(26), .NWORDS(8), .AW(8)) u_d26 (
    .clk(clk), .reset(reset), .req(req26), .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .ack(ack26), .busy(busy26), .mem_rd_en(rd26), .mem_we(we26),
    .mem_addr(addr26), .mem_rdata(rdata26), .mem_wdata(wdata26), .sec_cnt(sec26),
    .ded_cnt(ded26)
  );

  // Source memories are preloaded by the stimulus; writes are checked on the bus only.
  logic [31:0] mem11 [256];
  logic [31:0] mem4  [256];
  logic [31:0] mem26 [256];

  always @(posedge clk) begin
    if (rd11) rdata11 <= mem11[addr11][15:0];
    if (rd4)  rdata4  <= mem4[addr4][7:0];
    if (rd26) rdata26 <= mem26[addr26];
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q11[$];
  exp_t q4[$];
  exp_t q26[$];
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt[3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int dw);
    return (32'd1 << dw) - 32'd1;
  endfunction

  function automatic logic [31:0] m_place(input logic [31:0] data, input int cw);
    logic [31:0] w;
    int d;
    w = '0;
    d = 0;
    for (int pos = 1; pos < cw; pos++) begin
      if ($countones(pos) != 1) begin
        w[pos] = data[d];
        d++;
      end
    end
    return w;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] w, input int cw);
    logic [31:0] data;
    int d;
    data = '0;
    d = 0;
    for (int pos = 1; pos < cw; pos++) begin
      if ($countones(pos) != 1) begin
        data[d] = w[pos];
        d++;
      end
    end
    return data;
  endfunction

  // Parity bits are chosen so that the syndrome of the finished codeword is zero.
  function automatic logic [31:0] m_encode(input logic [31:0] data, input int dw, input int cw);
    logic [31:0] w;
    logic [4:0]  s;
    w = m_place(data & mask(dw), cw);
    s = '0;
    for (int pos = 1; pos < cw; pos++) if (w[pos]) s = s ^ pos[4:0];
    for (int k = 0; k < 5; k++) if ((1 << k) < cw) w[1 << k] = s[k];
    w[0] = ^w;
    return w;
  endfunction

  function automatic logic [31:0] m_decode(input logic [31:0] data, input logic [31:0] corrupt,
                                           input int nflips, input int dw, input int cw);
    logic [31:0] out;
    if (nflips == 2) begin
      out = m_extract(corrupt, cw) & mask(dw);
      out[cw-1] = 1'b1;
    end else begin
      out = data & mask(dw);
      if (nflips == 1) out[cw-2] = 1'b1;
    end
    return out;
  endfunction

  task automatic gen_dec(input int dw, input int cw, output logic [31:0] memword,
                         output logic [31:0] expword, output int n);
    logic [31:0] d, w;
    int p1, p2;
    d  = $urandom & mask(dw);
    w  = m_encode(d, dw, cw);
    n  = $urandom_range(0, 2);
    p1 = $urandom_range(0, cw - 1);
    p2 = (p1 + 1 + $urandom_range(0, cw - 2)) % cw;
    if (n >= 1) w[p1] = ~w[p1];
    if (n == 2) w[p2] = ~w[p2];
    memword = w;
    expword = m_decode(d, w, n, dw, cw);
  endtask

  task automatic mem_set(input int which, input logic [7:0] a, input logic [31:0] v);
    case (which)
      0: mem11[a] = v;
      1: mem4[a] = v;
      default: mem26[a] = v;
    endcase
  endtask

  task automatic push(input int which, input logic [7:0] a, input logic [31:0] v);
    exp_t e;
    e.addr = a;
    e.data = v;
    case (which)
      0: q11.push_back(e);
      1: q4.push_back(e);
      default: q26.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int which);
    case (which)
      0: return q11.size();
      1: return q4.size();
      default: return q26.size();
    endcase
  endfunction

  function automatic logic get_ack(input int which);
    case (which)
      0: return ack11;
      1: return ack4;
      default: return ack26;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0: return busy11;
      1: return busy4;
      default: return busy26;
    endcase
  endfunction

  function automatic logic [15:0] get_cnts(input int which);
    case (which)
      0: return {sec11, ded11};
      1: return {sec4, ded4};
      default: return {sec26, ded26};
    endcase
  endfunction

  task automatic set_req(input int which, input logic v);
    case (which)
      0: req11 = v;
      1: req4 = v;
      default: req26 = v;
    endcase
  endtask

  task automatic pop_check(input int which, input logic [7:0] a, input logic [31:0] v);
    exp_t e;
    int sz;
    wr_cnt[which]++;
    sz = qsize(which);
    e = '0;
    if (sz != 0) begin
      case (which)
        0: e = q11.pop_front();
        1: e = q4.pop_front();
        default: e = q26.pop_front();
      endcase
    end
    total++;
    assert (sz != 0) else begin
      bad++;
      $error("FAIL sb_unexpected_write[%0d]: observed addr=%h data=%h expected no write",
             which, a, v);
    end
    if (sz != 0) begin
      check($sformatf("wr_addr[%0d]", which), {24'h0, a}, {24'h0, e.addr});
      check($sformatf("wr_data[%0d]", which), v, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (we11) pop_check(0, addr11, {16'h0, wdata11});
    if (we4)  pop_check(1, addr4, {24'h0, wdata4});
    if (we26) pop_check(2, addr26, wdata26);
  end

  // Pulses req, optionally re-pulses it (with different mode/base) mid-job, and times ack.
  task automatic run_job(input int which, input logic md, input logic [7:0] sb,
                         input logic [7:0] db, input int glitch, input int exp_cyc);
    int   cyc;
    logic done;
    mode = md;
    src_base = sb;
    dst_base = db;
    set_req(which, 1'b1);
    @(posedge clk); #1;
    set_req(which, 1'b0);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      set_req(which, glitch != 0 && cyc == glitch);
      if (glitch != 0 && cyc == glitch) begin
        mode = ~md;
        src_base = sb + 8'd3;
      end
      if (glitch != 0 && cyc == glitch + 5) check("busy_mid_job", {31'h0, get_busy(which)}, 1);
      done = get_ack(which);
    end
    set_req(which, 1'b0);
    check($sformatf("latency[%0d]", which), cyc, exp_cyc);
  endtask

  task automatic sweep(input int which, input int dw, input int cw);
    logic [31:0] mw, ew, v;
    int n, es, ed;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        v = $urandom & mask(cw);
        mem_set(which, 8'(8'h20 + i), v);
        push(which, 8'(8'h60 + i), m_encode(v, dw, cw));
      end
      run_job(which, 1'b0, 8'h20, 8'h60, 0, 24);
      check($sformatf("enc_drain[%0d]", which), qsize(which), 0);
      es = 0;
      ed = 0;
      for (int i = 0; i < 8; i++) begin
        gen_dec(dw, cw, mw, ew, n);
        mem_set(which, 8'(8'h40 + i), mw);
        push(which, 8'(8'hFC + i), ew);
        es += (n == 1) ? 1 : 0;
        ed += (n == 2) ? 1 : 0;
      end
      run_job(which, 1'b1, 8'h40, 8'hFC, 0, 24);
      check($sformatf("dec_drain[%0d]", which), qsize(which), 0);
      check($sformatf("dec_cnts[%0d]", which), {16'h0, get_cnts(which)}, {16'h0, 8'(es), 8'(ed)});
    end
  endtask

  initial begin
    logic [31:0] mw, ew, v;
    logic [31:0] saved_mem[15];
    logic [31:0] saved_exp[15];
    int n, es, ed, snap, base, guard;

    reset = 1'b1;
    req11 = 1'b0;
    req4 = 1'b0;
    req26 = 1'b0;
    mode = 1'b0;
    src_base = '0;
    dst_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack11}, 0);
    check("rst_busy", {31'h0, busy11}, 0);
    check("rst_rd_en", {31'h0, rd11}, 0);
    check("rst_we", {31'h0, we11}, 0);
    check("rst_addr", {24'h0, addr11}, 0);
    check("rst_wdata", {16'h0, wdata11}, 0);
    check("rst_cnts", {16'h0, sec11, ded11}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Encode: all-zero and all-one data (upper input bits garbage), then random words.
    mem11[8'h10] = 32'h0000_0000;
    push(0, 8'hF5, 32'h0000_0000);
    mem11[8'h11] = 32'h0000_FFFF;
    push(0, 8'hF6, 32'h0000_FFFF);
    for (int i = 2; i < 15; i++) begin
      v = $urandom & 32'hFFFF;
      mem11[8'(8'h10 + i)] = v;
      push(0, 8'(8'hF5 + i), m_encode(v, 11, 16));
    end
    run_job(0, 1'b0, 8'h10, 8'hF5, 10, 45);
    check("enc_drain", qsize(0), 0);
    check("done_busy", {31'h0, busy11}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("ack_hold", {31'h0, ack11}, 1);

    // Decode with source addresses wrapping past 0xFF.
    mem11[8'hF8] = 32'hFFDF;
    push(0, 8'h80, 32'h47FF);
    mem11[8'hF9] = 32'hFFFE;
    push(0, 8'h81, 32'h47FF);
    mem11[8'hFA] = 32'hFFFC;
    push(0, 8'h82, 32'h87FF);
    es = 2;
    ed = 1;
    for (int i = 3; i < 15; i++) begin
      gen_dec(11, 16, mw, ew, n);
      mem11[8'(8'hF8 + i)] = mw;
      push(0, 8'(8'h80 + i), ew);
      es += (n == 1) ? 1 : 0;
      ed += (n == 2) ? 1 : 0;
    end
    run_job(0, 1'b1, 8'hF8, 8'h80, 0, 45);
    check("dec_drain", qsize(0), 0);
    check("dec_sec_cnt", {24'h0, sec11}, es);
    check("dec_ded_cnt", {24'h0, ded11}, ed);

    // Abort a decode job at word 7 with reset, then rerun it.
    es = 0;
    ed = 0;
    for (int i = 0; i < 15; i++) begin
      gen_dec(11, 16, mw, ew, n);
      saved_mem[i] = mw;
      saved_exp[i] = ew;
      mem11[8'(8'h30 + i)] = mw;
      push(0, 8'(8'hA0 + i), ew);
      es += (n == 1) ? 1 : 0;
      ed += (n == 2) ? 1 : 0;
    end
    mode = 1'b1;
    src_base = 8'h30;
    dst_base = 8'hA0;
    req11 = 1'b1;
    @(posedge clk); #1;
    req11 = 1'b0;
    base = wr_cnt[0];
    guard = 0;
    while (wr_cnt[0] - base < 7 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_reached_word7", wr_cnt[0] - base, 7);
    reset = 1'b1;
    #1;
    check("abort_ack", {31'h0, ack11}, 0);
    check("abort_busy", {31'h0, busy11}, 0);
    check("abort_we", {31'h0, we11}, 0);
    check("abort_cnts", {16'h0, sec11, ded11}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q11.delete();
    snap = wr_cnt[0];
    repeat (12) @(posedge clk);
    #1;
    check("no_write_after_reset", wr_cnt[0], snap);
    for (int i = 0; i < 15; i++) push(0, 8'(8'hA0 + i), saved_exp[i]);
    run_job(0, 1'b1, 8'h30, 8'hA0, 0, 45);
    check("restart_drain", qsize(0), 0);
    check("restart_writes", wr_cnt[0] - snap, 15);
    check("restart_sec_cnt", {24'h0, sec11}, es);
    check("restart_ded_cnt", {24'h0, ded11}, ed);
    check("restart_src_intact", saved_mem[7], mem11[8'h37]);

    sweep(1, 4, 8);
    sweep(2, 26, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_secded_engine.md
HAMMING_SECDED_ENGINE -- requirements
Module: hamming_secded_engine

Interface
REQ-001 Parameter DW, default 11: message data bits; legal values 4, 11, 26.
REQ-002 Parameter CW, default DW+$clog2(DW+1)+1 (8/16/32): codeword width including overall parity.
REQ-003 Parameter NWORDS, default 15: words processed per request, 1..255.
REQ-004 Parameter AW, default 8: data-memory word address width.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high master reset.
REQ-007 req  in  1  start request, sampled high for at least one cycle.
REQ-008 mode  in  1  0 = encode, 1 = decode; captured when req accepted.
REQ-009 src_base, dst_base  in  AW  first source and destination word address; captured with req.
REQ-010 ack  out  1  job complete.
REQ-011 busy  out  1  job in progress.
REQ-012 mem_rd_en  out  1, mem_we  out  1, mem_addr  out  AW: memory strobes and address.
REQ-013 mem_rdata  in  CW  read data, valid exactly one cycle after mem_rd_en.
REQ-014 mem_wdata  out  CW  write data, written when mem_we high.
REQ-015 sec_cnt, ded_cnt  out  8  single-corrected / double-detected word counts for the last decode job.

Function
REQ-016 Codeword layout SHALL be: bit i (1..CW-1) = Hamming position i; power-of-two positions hold parity; data bits d1..dDW fill the remaining positions in ascending order; bit 0 = XOR of bits 1..CW-1.
REQ-017 Parity at position 2^k SHALL be the XOR of all data positions whose index has bit k set.
REQ-018 FSM states SHALL be IDLE, RD, CAP, WR, DONE.
REQ-019 IDLE/DONE with req high SHALL go to RD, capture mode/bases, clear word index, clear sec_cnt/ded_cnt on decode, drop ack.
REQ-020 RD SHALL assert mem_rd_en with mem_addr = src_base+index, then go to CAP.
REQ-021 CAP SHALL register mem_rdata and the computed result, then go to WR.
REQ-022 WR SHALL assert mem_we with mem_addr = dst_base+index; go to DONE if index = NWORDS-1, else increment index and go to RD.
REQ-023 DONE SHALL hold ack high until the next accepted req; busy is high in RD, CAP and WR only.
REQ-024 Job latency SHALL be 3*NWORDS cycles from req sample to first cycle of ack high.
REQ-025 req in RD/CAP/WR SHALL be ignored.
REQ-026 Address arithmetic SHALL wrap modulo 2^AW.
REQ-027 Encode: input = mem_rdata[DW-1:0], upper bits ignored; output = full CW-bit codeword.
REQ-028 Decode: syndrome s = XOR of indices of set bits 1..CW-1; p = XOR of all CW bits.
REQ-029 s=0, p=0: output data unchanged, no flag.
REQ-030 p=1: single error; flip bit s if s!=0 (s=0 means bit 0 erred); set SEC flag; sec_cnt+1.
REQ-031 s!=0, p=0: double error; no correction; set DED flag; ded_cnt+1.
REQ-032 Decode output: bit CW-1 = DED, bit CW-2 = SEC, bits DW-1:0 = data, all other bits 0.
REQ-033 Counters SHALL saturate at 255.

Reset
REQ-034 reset SHALL force IDLE asynchronously; ack, busy, mem_rd_en, mem_we = 0; mem_addr, mem_wdata, counters, index = 0.
REQ-035 Reset mid-job SHALL abort with no further memory writes; the next req restarts the job from index 0.

Structure
REQ-036 Package secded_pkg SHALL hold the state enum, the mode enum, and the encode/syndrome functions parameterised by DW/CW.
REQ-037 Combinational sub-module secded_codec (encode and decode-correct) SHALL be instantiated once; the FSM stays in hamming_secded_engine.

Verification
REQ-038 DW=11, encode 11'h000 -> 16'h0000; encode 11'h7FF -> 16'hFFFF.
REQ-039 Decode 16'hFFDF (bit 5 flipped) -> 16'h47FF, sec_cnt=1.
REQ-040 Decode 16'hFFFE (bit 0 flipped) -> 16'h47FF; decode 16'hFFFC (bits 0, 1 flipped) -> 16'h87FF, ded_cnt=1.
REQ-041 NWORDS=15 job -> ack exactly 45 cycles after req; second req pulse during busy -> no effect.
REQ-042 Reset at word 7 -> ack=0, no writes after reset; new req -> all 15 words correct.
REQ-043 Random sweep over DW 4/11/26: encode, inject 0/1/2 flips, decode; data and flags SHALL match the reference model.
